// File: rtl/axis_ipg_gate.sv
// axis_ipg_gate: inter-packet-gap gate for an AXI-Stream replay path.
// Holds each packet's head beat until the gap carried in its TUSER field has
// elapsed since the previous downstream TLAST, then forwards the packet
// unmodified. Only TVALID/TREADY are gated; payload passes straight through.
// Optional statistics counters are built when AXIS_IPG_GATE_STATS_EN is defined.
module axis_ipg_gate #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DELAY_LSB          = 32,
  parameter int DELAY_WIDTH        = 32
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            gate_en,
  input  logic                            sw_rst,
  output logic [31:0]                     stat_pkt_cnt,
  output logic [31:0]                     stat_stall_cnt
);

  typedef enum logic [0:0] {
    HEAD = 1'b0,
    BODY = 1'b1
  } state_t;

  localparam logic [DELAY_WIDTH-1:0] GAP_ONES = {DELAY_WIDTH{1'b1}};
  localparam logic [DELAY_WIDTH-1:0] GAP_ZERO = {DELAY_WIDTH{1'b0}};
  localparam logic [DELAY_WIDTH-1:0] GAP_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DELAY_WIDTH-1:0] gap_cnt_r;
  logic [DELAY_WIDTH-1:0] gap_cnt_nxt_s;
  logic [DELAY_WIDTH-1:0] delay_s;
  logic                   open_s;
  logic                   gate_s;
  logic                   m_hs_s;

  // Payload fields pass through untouched.
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tstrb = s_axis_tstrb;
  assign m_axis_tuser = s_axis_tuser;
  assign m_axis_tlast = s_axis_tlast;

  // Gap requirement of the beat currently presented; zero when gating is off.
  always_comb begin
    delay_s = GAP_ZERO;
    if (gate_en) begin
      delay_s = s_axis_tuser[DELAY_LSB +: DELAY_WIDTH];
    end else begin
      delay_s = GAP_ZERO;
    end
  end

  // Gate is open mid-packet or once the gap has elapsed; forced shut in reset.
  assign open_s        = (state_r == BODY) || (gap_cnt_r >= delay_s);
  assign gate_s        = open_s & axi_aresetn & ~sw_rst;
  assign m_axis_tvalid = s_axis_tvalid & gate_s;
  assign s_axis_tready = m_axis_tready & gate_s;
  assign m_hs_s        = m_axis_tvalid & m_axis_tready;

  // Next packet-position state from downstream handshakes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HEAD: begin
        if (m_hs_s && !s_axis_tlast) begin
          state_nxt_s = BODY;
        end else begin
          state_nxt_s = HEAD;
        end
      end
      BODY: begin
        if (m_hs_s && s_axis_tlast) begin
          state_nxt_s = HEAD;
        end else begin
          state_nxt_s = BODY;
        end
      end
      default: state_nxt_s = HEAD;
    endcase
  end

  // Idle-gap counter: cleared after a TLAST handshake, otherwise saturating count-up.
  always_comb begin
    gap_cnt_nxt_s = gap_cnt_r;
    if (m_hs_s && s_axis_tlast) begin
      gap_cnt_nxt_s = GAP_ZERO;
    end else if (gap_cnt_r != GAP_ONES) begin
      gap_cnt_nxt_s = gap_cnt_r + GAP_ONE;
    end else begin
      gap_cnt_nxt_s = GAP_ONES;
    end
  end

  // State and gap counter registers; a reset releases the first packet at once.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r   <= HEAD;
      gap_cnt_r <= GAP_ONES;
    end else if (sw_rst) begin
      state_r   <= HEAD;
      gap_cnt_r <= GAP_ONES;
    end else begin
      state_r   <= state_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

`ifdef AXIS_IPG_GATE_STATS_EN
  logic [31:0] pkt_cnt_r;
  logic [31:0] stall_cnt_r;

  // Packet and head-stall statistics, wrapping 32-bit counters.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_cnt_r   <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else if (sw_rst) begin
      pkt_cnt_r   <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (m_hs_s && s_axis_tlast) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
      if ((state_r == HEAD) && s_axis_tvalid && !open_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign stat_pkt_cnt   = pkt_cnt_r;
  assign stat_stall_cnt = stall_cnt_r;
`else
  assign stat_pkt_cnt   = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule
